edge_updown_counter: RTL and testbench

- Parametrised up/down counter driven by asynchronous level inputs (push-buttons, switches); successor to the fixed 4-bit edge-flag counter.
- Each input is synchronised, then rising-edge detected; one count step per press. Counter range is bounded [MIN_VAL, MAX_VAL] with wrap or saturate mode, parallel load, and carry/borrow pulses for cascading digits (e.g. clock/timer fields).

---
 rtl/edge_updown_counter.sv | 99 +++++++++
 tb/tb_edge_updown_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/edge_updown_counter.sv
// rtl/edge_updown_counter.sv - bounded up/down counter stepped by synchronised button edges
module edge_updown_counter #(
  parameter int WIDTH       = 8,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 59,
  parameter int WRAP        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_in,
  input  logic             down_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             carry_pulse,
  output logic             borrow_pulse
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);

  logic [SYNC_STAGES-1:0] up_sync;
  logic [SYNC_STAGES-1:0] down_sync;
  logic                   up_prev;
  logic                   down_prev;
  logic                   up_edge;
  logic                   down_edge;

  logic [WIDTH-1:0] q_next;
  logic             carry_next;
  logic             borrow_next;

  // Synchronisers and edge history run through reset so a held button
  // cannot produce a phantom step once reset releases.
  always_ff @(posedge clk) begin
    up_sync   <= {up_sync[SYNC_STAGES-2:0], up_in};
    down_sync <= {down_sync[SYNC_STAGES-2:0], down_in};
    up_prev   <= up_sync[SYNC_STAGES-1];
    down_prev <= down_sync[SYNC_STAGES-1];
  end

  assign up_edge   = up_sync[SYNC_STAGES-1] & ~up_prev;
  assign down_edge = down_sync[SYNC_STAGES-1] & ~down_prev;

  always_comb begin
    q_next      = q;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (load) begin
      if (load_val > MAX_Q)
        q_next = MAX_Q;
      else if (load_val < MIN_Q)
        q_next = MIN_Q;
      else
        q_next = load_val;
    end else if (up_edge ^ down_edge) begin
      if (up_edge) begin
        if (q >= MAX_Q) begin
          if (WRAP != 0) begin
            q_next     = MIN_Q;
            carry_next = 1'b1;
          end
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (q <= MIN_Q) begin
          if (WRAP != 0) begin
            q_next      = MAX_Q;
            borrow_next = 1'b1;
          end
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  // Flags are derived from q_next so they land in the same cycle as q.
  always_ff @(posedge clk) begin
    if (reset) begin
      q            <= MIN_Q;
      at_min       <= 1'b1;
      at_max       <= 1'b0;
      carry_pulse  <= 1'b0;
      borrow_pulse <= 1'b0;
    end else begin
      q            <= q_next;
      at_min       <= (q_next == MIN_Q);
      at_max       <= (q_next == MAX_Q);
      carry_pulse  <= carry_next;
      borrow_pulse <= borrow_next;
    end
  end

endmodule

// File: tb/tb_edge_updown_counter.sv
// tb/tb_edge_updown_counter.sv - directed bench for wrap and saturate counter instances
module tb_edge_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       up_in, down_in, load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       at_max, at_min, carry_pulse, borrow_pulse;

  logic       s_up, s_down, s_load;
  logic [7:0] s_load_val;
  logic [7:0] s_q;
  logic       s_at_max, s_at_min, s_carry, s_borrow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  edge_updown_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(59), .WRAP(1), .SYNC_STAGES(2)) dut_wrap (
    .clk(clk), .reset(reset), .up_in(up_in), .down_in(down_in), .load(load),
    .load_val(load_val), .q(q), .at_max(at_max), .at_min(at_min),
    .carry_pulse(carry_pulse), .borrow_pulse(borrow_pulse)
  );

  edge_updown_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(59), .WRAP(0), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .reset(reset), .up_in(s_up), .down_in(s_down), .load(s_load),
    .load_val(s_load_val), .q(s_q), .at_max(s_at_max), .at_min(s_at_min),
    .carry_pulse(s_carry), .borrow_pulse(s_borrow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press_up;
    up_in = 1'b1;
    tick; tick;
    up_in = 1'b0;
    repeat (4) tick;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (q !== 8'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", q); end
    total++; if ({at_min, at_max, carry_pulse, borrow_pulse} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000", {at_min, at_max, carry_pulse, borrow_pulse}); end
    total++; if (s_q !== 8'd0 || s_at_min !== 1'b1) begin
      bad++; $display("FAIL reset_sat got q=%0d at_min=%b exp q=0 at_min=1", s_q, s_at_min); end
  endtask

  task automatic test_latency;
    up_in = 1'b1;
    tick;
    total++; if (q !== 8'd0) begin bad++; $display("FAIL lat_edge1 got=%0d exp=0", q); end
    tick;
    total++; if (q !== 8'd0) begin bad++; $display("FAIL lat_edge2 got=%0d exp=0", q); end
    tick;
    total++; if (q !== 8'd1) begin bad++; $display("FAIL lat_edge3 got=%0d exp=1", q); end
    tick; tick;
    total++; if (q !== 8'd1) begin bad++; $display("FAIL lat_hold got=%0d exp=1", q); end
    up_in = 1'b0;
    repeat (4) tick;
    total++; if (q !== 8'd1) begin bad++; $display("FAIL lat_release got=%0d exp=1", q); end
  endtask

  task automatic test_count_and_wrap;
    do_reset;
    repeat (59) press_up;
    total++; if (q !== 8'd59 || at_max !== 1'b1 || at_min !== 1'b0) begin
      bad++; $display("FAIL count59 got q=%0d at_max=%b at_min=%b exp 59/1/0", q, at_max, at_min); end
    up_in = 1'b1;
    tick; tick;
    total++; if (q !== 8'd59 || carry_pulse !== 1'b0) begin
      bad++; $display("FAIL carry_early got q=%0d carry=%b exp 59/0", q, carry_pulse); end
    tick;
    total++; if (q !== 8'd0 || carry_pulse !== 1'b1 || at_min !== 1'b1 || at_max !== 1'b0 || borrow_pulse !== 1'b0) begin
      bad++; $display("FAIL carry_wrap got q=%0d carry=%b at_min=%b at_max=%b borrow=%b exp 0/1/1/0/0",
                      q, carry_pulse, at_min, at_max, borrow_pulse); end
    tick;
    total++; if (carry_pulse !== 1'b0 || q !== 8'd0) begin
      bad++; $display("FAIL carry_width got carry=%b q=%0d exp 0/0", carry_pulse, q); end
    up_in = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_saturate;
    s_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (s_q !== 8'd0 || s_borrow !== 1'b0) begin
        bad++; $display("FAIL sat_down cyc=%0d got q=%0d borrow=%b exp 0/0", i, s_q, s_borrow); end
    end
    s_down = 1'b0;
    repeat (4) tick;
    s_load = 1'b1; s_load_val = 8'd200;
    tick;
    s_load = 1'b0;
    total++; if (s_q !== 8'd59 || s_at_max !== 1'b1) begin
      bad++; $display("FAIL sat_load got q=%0d at_max=%b exp 59/1", s_q, s_at_max); end
    s_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (s_q !== 8'd59 || s_carry !== 1'b0) begin
        bad++; $display("FAIL sat_up cyc=%0d got q=%0d carry=%b exp 59/0", i, s_q, s_carry); end
    end
    s_up = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_simultaneous_and_borrow;
    load = 1'b1; load_val = 8'd10;
    tick;
    load = 1'b0;
    total++; if (q !== 8'd10) begin bad++; $display("FAIL load10 got=%0d exp=10", q); end
    up_in = 1'b1; down_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++; if (q !== 8'd10 || carry_pulse !== 1'b0 || borrow_pulse !== 1'b0) begin
        bad++; $display("FAIL both cyc=%0d got q=%0d c=%b b=%b exp 10/0/0", i, q, carry_pulse, borrow_pulse); end
    end
    up_in = 1'b0; down_in = 1'b0;
    repeat (4) tick;
    load = 1'b1; load_val = 8'd0;
    tick;
    load = 1'b0;
    down_in = 1'b1;
    tick; tick;
    total++; if (q !== 8'd0 || borrow_pulse !== 1'b0) begin
      bad++; $display("FAIL borrow_early got q=%0d borrow=%b exp 0/0", q, borrow_pulse); end
    tick;
    total++; if (q !== 8'd59 || borrow_pulse !== 1'b1 || carry_pulse !== 1'b0 || at_max !== 1'b1) begin
      bad++; $display("FAIL borrow_wrap got q=%0d borrow=%b carry=%b at_max=%b exp 59/1/0/1",
                      q, borrow_pulse, carry_pulse, at_max); end
    tick;
    total++; if (borrow_pulse !== 1'b0 || q !== 8'd59) begin
      bad++; $display("FAIL borrow_width got borrow=%b q=%0d exp 0/59", borrow_pulse, q); end
    down_in = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_load_vs_edge;
    up_in = 1'b1;
    tick; tick;
    load = 1'b1; load_val = 8'd30;
    tick;
    load = 1'b0;
    total++; if (q !== 8'd30) begin bad++; $display("FAIL load_edge got=%0d exp=30", q); end
    tick; tick;
    total++; if (q !== 8'd30) begin bad++; $display("FAIL load_edge_hold got=%0d exp=30", q); end
    up_in = 1'b0;
    repeat (4) tick;
    press_up;
    total++; if (q !== 8'd31) begin bad++; $display("FAIL load_next got=%0d exp=31", q); end
  endtask

  task automatic test_reset_mid_press;
    up_in = 1'b1;
    tick; tick; tick;
    reset = 1'b1;
    repeat (4) tick;
    reset = 1'b0;
    total++; if (q !== 8'd0 || at_min !== 1'b1) begin
      bad++; $display("FAIL rst_press got q=%0d at_min=%b exp 0/1", q, at_min); end
    repeat (5) tick;
    total++; if (q !== 8'd0) begin bad++; $display("FAIL rst_press_hold got=%0d exp=0", q); end
    up_in = 1'b0;
    repeat (4) tick;
    press_up;
    total++; if (q !== 8'd1) begin bad++; $display("FAIL rst_repress got=%0d exp=1", q); end
  endtask

  initial begin
    reset = 1'b0; up_in = 1'b0; down_in = 1'b0; load = 1'b0; load_val = 8'd0;
    s_up = 1'b0; s_down = 1'b0; s_load = 1'b0; s_load_val = 8'd0;
    repeat (4) tick;
    test_reset;
    test_latency;
    test_count_and_wrap;
    test_saturate;
    test_simultaneous_and_borrow;
    test_load_vs_edge;
    test_reset_mid_press;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
